sprite_slot_scheduler: RTL

// - Allocates and sequences NUM_SLOTS scrolling sprite slots (clouds/obstacles) for the background renderer.
// - Enforces a minimum spawn gap, randomises the spawn Y position and moves active slots left once per tick.
// - Presents registered slot_en/xpos/ypos vectors that feed the per-slot mem_addr_gen/ROM readers.

---
 rtl/sprite_slot_scheduler_pkg.sv | 34 +++
 rtl/sprite_slot_scheduler_slot_pick.sv | 31 +++
 rtl/sprite_slot_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sprite_slot_scheduler_pkg.sv
// Shared game-level encodings, screen/sprite geometry and small helpers
// used by the sprite slot scheduler and its sub-blocks.
package sprite_slot_scheduler_pkg;

    typedef enum logic [1:0] {
        GAME_INIT  = 2'd0,
        GAME_START = 2'd1,
        GAME_END   = 2'd2,
        GAME_RESET = 2'd3
    } game_state_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2,
        ST_CLEAR  = 2'd3
    } sched_state_e;

    localparam int WINDOW_WIDTH  = 640;
    localparam int SPRITE_WIDTH  = 52;
    localparam int SPRITE_HEIGHT = 44;
    localparam int POS_W         = 11;

    // Number of set bits in an up-to-8-bit slot mask.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sprite_slot_scheduler_slot_pick.sv
// Combinational free-slot finder: scans the free mask starting at i_start,
// wrapping around, and returns the first free index plus a found flag.
module sprite_slot_scheduler_slot_pick #(
    parameter int NUM_SLOTS = 3,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_SLOTS-1:0] i_free,
    input  logic [IDX_W-1:0]     i_start,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_found
);

    logic [IDX_W:0] w_pos;
    logic           w_hit;

    // One extra bit on the position keeps start+offset from overflowing before the wrap.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_pos   = '0;
        w_hit   = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            w_pos   = {1'b0, i_start} + (IDX_W+1)'(k);
            w_pos   = (w_pos >= (IDX_W+1)'(NUM_SLOTS)) ? (w_pos - (IDX_W+1)'(NUM_SLOTS)) : w_pos;
            w_hit   = !o_found && i_free[w_pos[IDX_W-1:0]];
            o_idx   = w_hit ? w_pos[IDX_W-1:0] : o_idx;
            o_found = o_found | w_hit;
        end
    end

endmodule

// File: rtl/sprite_slot_scheduler.sv
// Sprite slot scheduler: spawns, scrolls and retires background sprite slots.
// Optional SLOT_ROUND_ROBIN_EN: free-slot search rotates from the slot after the last spawn.
module sprite_slot_scheduler
    import sprite_slot_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS   = 3,
    parameter int MIN_GAP     = 150,
    parameter int SKIP_THRESH = 10,
    parameter int SKIP_RELOAD = 80,
    parameter int FULL_RELOAD = 50,
    parameter int SPAWN_X     = WINDOW_WIDTH + SPRITE_WIDTH,
    parameter int Y_BASE      = 240
) (
    input  logic                         game_clk,
    input  logic                         rst,
    input  logic                         i_tick,
    input  logic [1:0]                   i_game_state,
    input  logic [6:0]                   i_rand_val,
    input  logic                         i_spawn_req,
    output logic [NUM_SLOTS-1:0]         o_slot_en,
    output logic [POS_W*NUM_SLOTS-1:0]   o_slot_xpos,
    output logic [POS_W*NUM_SLOTS-1:0]   o_slot_ypos,
    output logic                         o_spawn_ack,
    output logic                         o_spawn_skip,
    output logic                         o_spawn_full,
    output logic [3:0]                   o_active_cnt
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    sched_state_e         r_state;
    logic [7:0]           r_gap_cnt;
    logic [NUM_SLOTS-1:0] r_slot_en;
    logic [POS_W-1:0]     r_xpos [NUM_SLOTS];
    logic [POS_W-1:0]     r_ypos [NUM_SLOTS];
    logic                 r_spawn_ack;
    logic                 r_spawn_skip;
    logic                 r_spawn_full;

    logic [IDX_W-1:0]     w_start;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_found;
    logic                 w_gap_met;
    logic                 w_skip;
    logic                 w_clear;
    logic [POS_W-1:0]     w_spawn_y;

`ifdef SLOT_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     r_rr_ptr;
    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    // Free mask comes from the pre-tick enables, so a slot retiring this tick is not reused.
    sprite_slot_scheduler_slot_pick #(
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) u_slot_pick (
        .i_free  (~r_slot_en),
        .i_start (w_start),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    assign w_gap_met = r_gap_cnt > 8'(MIN_GAP);
    assign w_skip    = i_rand_val < 7'(SKIP_THRESH);
    assign w_spawn_y = POS_W'(Y_BASE) - {4'd0, i_rand_val};
    assign w_clear   = (i_game_state == GAME_RESET) ||
                       ((r_state != ST_RUN) && (r_state != ST_FREEZE));

    // Scheduler FSM with registered slot state and one-cycle status pulses.
    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_gap_cnt    <= 8'd0;
            r_slot_en    <= '0;
            r_spawn_ack  <= 1'b0;
            r_spawn_skip <= 1'b0;
            r_spawn_full <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_xpos[i] <= '0;
                r_ypos[i] <= '0;
            end
`ifdef SLOT_ROUND_ROBIN_EN
            r_rr_ptr     <= '0;
`endif
        end else begin
            r_spawn_ack  <= 1'b0;
            r_spawn_skip <= 1'b0;
            r_spawn_full <= 1'b0;

            if (w_clear) begin
                r_gap_cnt <= 8'd0;
                r_slot_en <= '0;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    r_xpos[i] <= '0;
                    r_ypos[i] <= '0;
                end
`ifdef SLOT_ROUND_ROBIN_EN
                r_rr_ptr  <= '0;
`endif
            end else if ((r_state == ST_RUN) && i_tick) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (r_slot_en[i]) begin
                        if (r_xpos[i] == 11'd0) r_slot_en[i] <= 1'b0;
                        else                    r_xpos[i]    <= r_xpos[i] - 11'd1;
                    end
                end
                if (!w_gap_met) begin
                    if (r_gap_cnt != 8'hFF) r_gap_cnt <= r_gap_cnt + 8'd1;
                end else if (i_spawn_req) begin
                    if (!w_pick_found) begin
                        r_gap_cnt    <= 8'(FULL_RELOAD);
                        r_spawn_full <= 1'b1;
                    end else if (w_skip) begin
                        r_gap_cnt    <= 8'(SKIP_RELOAD);
                        r_spawn_skip <= 1'b1;
                    end else begin
                        r_slot_en[w_pick_idx] <= 1'b1;
                        r_xpos[w_pick_idx]    <= POS_W'(SPAWN_X);
                        r_ypos[w_pick_idx]    <= w_spawn_y;
                        r_gap_cnt             <= 8'd0;
                        r_spawn_ack           <= 1'b1;
`ifdef SLOT_ROUND_ROBIN_EN
                        r_rr_ptr <= (w_pick_idx == IDX_W'(NUM_SLOTS-1)) ? '0 : (w_pick_idx + IDX_W'(1));
`endif
                    end
                end
            end

            if (i_game_state == GAME_RESET) begin
                r_state <= ST_CLEAR;
            end else begin
                case (r_state)
                    ST_IDLE:   if (i_game_state == GAME_START) r_state <= ST_RUN;
                    ST_RUN:    if (i_game_state == GAME_END)   r_state <= ST_FREEZE;
                    ST_FREEZE: if (i_game_state == GAME_START) r_state <= ST_RUN;
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SLOTS; g++) begin : g_pos
            assign o_slot_xpos[POS_W*g +: POS_W] = r_xpos[g];
            assign o_slot_ypos[POS_W*g +: POS_W] = r_ypos[g];
        end
    endgenerate

    assign o_slot_en    = r_slot_en;
    assign o_spawn_ack  = r_spawn_ack;
    assign o_spawn_skip = r_spawn_skip;
    assign o_spawn_full = r_spawn_full;
    assign o_active_cnt = popcount8(8'(r_slot_en));

endmodule
